// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 pipelined-datapath scheduler.
package aes128_pkg;

  localparam int unsigned AES_BLK_W   = 128;
  localparam int unsigned LATENCY_DEF = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } sched_state_e;

  // A datapath configuration: the key and the direction (0 encrypt, 1 decrypt).
  typedef struct packed {
    logic [AES_BLK_W-1:0] key;
    logic                 sel;
  } cfg_t;

endpackage

// File: rtl/aes_rr_arb.sv
// Two-way round-robin arbiter: picks the priority requester when it is valid, otherwise the
// other one; the pointer moves past the winner only when a grant is taken.
module aes_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic       winner,
  output logic       any_valid
);

  logic ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= ~winner;
    end
  end

  assign any_valid = |valid;
  assign winner    = valid[ptr_q] ? ptr_q : ~ptr_q;

endmodule

// File: rtl/aes128_pip_sched.sv
// Config-batching scheduler feeding a pipelined AES-128 datapath from two requesters.
// Optional AES_SCHED_ZEROIZE_EN clears the held key on drain and after a long idle spell in RUN.
module aes128_pip_sched
  import aes128_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned NREQ    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_BLK_W-1:0] req0_data,
  input  logic [AES_BLK_W-1:0] req0_key,
  input  logic                 req0_sel,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AES_BLK_W-1:0] req1_data,
  input  logic [AES_BLK_W-1:0] req1_key,
  input  logic                 req1_sel,
  output logic [AES_BLK_W-1:0] dp_in,
  output logic [AES_BLK_W-1:0] dp_key,
  output logic                 dp_sel,
  input  logic [AES_BLK_W-1:0] dp_out,
  output logic                 out_valid,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 out_id
);

  sched_state_e       state_q, state_d;
  cfg_t               cfg_q, cfg_d;
  cfg_t               cfg0, cfg1, win_cfg;
  logic [NREQ-1:0]    req_valid;
  logic               winner, any_valid, grant, cfg_match, tracker_empty;
  logic [LATENCY-1:0] vld_q, id_q;

`ifdef AES_SCHED_ZEROIZE_EN
  logic [3:0] idle_cnt_q, idle_cnt_d;
`endif

  assign req_valid     = {req1_valid, req0_valid};
  assign cfg0          = '{key: req0_key, sel: req0_sel};
  assign cfg1          = '{key: req1_key, sel: req1_sel};
  assign win_cfg       = winner ? cfg1 : cfg0;
  assign cfg_match     = (win_cfg == cfg_q);
  assign tracker_empty = ~|vld_q;

  aes_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid    (req_valid),
    .advance  (grant),
    .winner   (winner),
    .any_valid(any_valid)
  );

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    grant   = 1'b0;
`ifdef AES_SCHED_ZEROIZE_EN
    idle_cnt_d = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          cfg_d   = win_cfg;
          state_d = StRun;
        end
      end
      StRun: begin
        // The winner is the priority requester whenever it is valid, so a mismatch there
        // forces a drain instead of letting the matching side starve it.
        if (any_valid) begin
          if (cfg_match) begin
            grant = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end
`ifdef AES_SCHED_ZEROIZE_EN
        else if (tracker_empty) begin
          idle_cnt_d = idle_cnt_q + 4'd1;
          if (idle_cnt_q == 4'd15) begin
            idle_cnt_d = '0;
            cfg_d.key  = '0;
            state_d    = StIdle;
          end
        end
`endif
      end
      StDrain: begin
        if (tracker_empty) begin
          state_d = StIdle;
`ifdef AES_SCHED_ZEROIZE_EN
          cfg_d.key = '0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cfg_q   <= '0;
      vld_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      vld_q   <= {vld_q[LATENCY-2:0], grant};
      id_q    <= {id_q[LATENCY-2:0], winner};
    end
  end

`ifdef AES_SCHED_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  assign req0_ready = grant & ~winner;
  assign req1_ready = grant & winner;
  assign dp_in      = grant ? (winner ? req1_data : req0_data) : '0;
  assign dp_key     = cfg_q.key;
  assign dp_sel     = cfg_q.sel;
  assign out_valid  = vld_q[LATENCY-1];
  assign out_id     = id_q[LATENCY-1];
  assign out_data   = dp_out;

endmodule
